// File: rtl/xgemac_rx_pkt_reader.sv
// xgemac_rx_pkt_reader: pulls frames from the XGEMAC rx port into a small FIFO,
// repairs framing (stray words dropped, early sop restarts) and keeps saturating stats.
module xgemac_rx_pkt_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_mod,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] framing_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nx;
  logic [69:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic in_frame, room, empty, val_eop, stray, restart, wr, rd;
  logic [3:0] byte_inc;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  // two free slots cover the word already in flight plus the one being requested
  assign room = count <= (AW+1)'(FIFO_DEPTH - 2);
  assign empty = count == '0;
  assign val_eop = pkt_rx_val && pkt_rx_eop;
  assign stray = pkt_rx_val && !pkt_rx_sop && !in_frame;
  assign restart = pkt_rx_val && pkt_rx_sop && in_frame;
  assign wr = pkt_rx_val && !stray;
  assign rd = out_valid && out_ready;
  assign byte_inc = (!pkt_rx_eop || pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, pkt_rx_mod};
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? ((pkt_rx_avail && room) ? READ : IDLE) : (val_eop ? IDLE : READ);
  end
  assign pkt_rx_ren = (state == READ) && room && !val_eop;
  assign out_valid = !empty;
  assign {out_data, out_sop, out_eop, out_mod, out_err} = empty ? 70'd0 : mem[rd_ptr];
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n)
    if (!reset_156m25_n) begin
      state <= IDLE;
      in_frame <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (wr) in_frame <= !pkt_rx_eop;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk_156m25)
    if (wr) mem[wr_ptr] <= {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err};
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n)
    if (!reset_156m25_n) begin
      frame_cnt <= '0;
      byte_cnt <= '0;
      err_cnt <= '0;
      framing_err_cnt <= '0;
    end else if (stats_clr) begin
      frame_cnt <= '0;
      byte_cnt <= '0;
      err_cnt <= '0;
      framing_err_cnt <= '0;
    end else begin
      if (wr) byte_cnt <= sat_add(byte_cnt, byte_inc);
      if (wr && pkt_rx_eop) frame_cnt <= sat_add(frame_cnt, 4'd1);
      if (wr && pkt_rx_eop && pkt_rx_err) err_cnt <= sat_add(err_cnt, 4'd1);
      if (stray || restart) framing_err_cnt <= sat_add(framing_err_cnt, 4'd1);
    end
endmodule

// File: tb/tb_xgemac_rx_pkt_reader.sv
// tb_xgemac_rx_pkt_reader: directed + random frames through a MAC model, checked
// against a word-level reference queue and unbounded counters saturated per width.
module tb_xgemac_rx_pkt_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, avail = 1'b0, val = 1'b0, sop = 1'b0, eop = 1'b0, err = 1'b0;
  logic out_ready = 1'b1, stats_clr = 1'b0;
  logic [2:0] mod = 3'd0;
  logic [63:0] data = 64'd0;
  logic ren, out_sop, out_eop, out_err, out_valid;
  logic [2:0] out_mod;
  logic [63:0] out_data;
  logic [31:0] frame_cnt, byte_cnt, err_cnt, ferr_cnt;
  logic s_ren, s_sop, s_eop, s_err, s_valid;
  logic [2:0] s_mod;
  logic [63:0] s_data;
  logic [3:0] s_frame_cnt, s_byte_cnt, s_err_cnt, s_ferr_cnt;
  int checks = 0, fails = 0, mac_sent = 0;
  logic [69:0] mac_q[$], exp_q[$], got_q[$];
  longint m_frames = 0, m_bytes = 0, m_errs = 0, m_ferr = 0;
  bit m_in = 1'b0, ren_s = 1'b0;

  xgemac_rx_pkt_reader #(.FIFO_DEPTH(4), .CNT_W(32)) u_dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .pkt_rx_avail(avail), .pkt_rx_ren(ren),
    .pkt_rx_data(data), .pkt_rx_val(val), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_mod(mod), .pkt_rx_err(err), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_mod(out_mod), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .stats_clr(stats_clr), .frame_cnt(frame_cnt),
    .byte_cnt(byte_cnt), .err_cnt(err_cnt), .framing_err_cnt(ferr_cnt));

  xgemac_rx_pkt_reader #(.FIFO_DEPTH(4), .CNT_W(4)) u_sat (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .pkt_rx_avail(avail), .pkt_rx_ren(s_ren),
    .pkt_rx_data(data), .pkt_rx_val(val), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_mod(mod), .pkt_rx_err(err), .out_data(s_data), .out_sop(s_sop),
    .out_eop(s_eop), .out_mod(s_mod), .out_err(s_err), .out_valid(s_valid),
    .out_ready(out_ready), .stats_clr(stats_clr), .frame_cnt(s_frame_cnt),
    .byte_cnt(s_byte_cnt), .err_cnt(s_err_cnt), .framing_err_cnt(s_ferr_cnt));

  // MAC model: a read granted in one cycle returns its word in the next
  always @(negedge clk) ren_s = ren;
  always @(posedge clk) begin
    #1;
    if (ren_s && mac_q.size() != 0) begin
      {data, sop, eop, mod, err} = mac_q.pop_front();
      val = 1'b1;
      mac_sent++;
    end else val = 1'b0;
    avail = mac_q.size() != 0;
  end
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) got_q.push_back({out_data, out_sop, out_eop, out_mod, out_err});

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint lim(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return v > mx ? mx : v;
  endfunction

  // reference: apply the framing and counting rules word by word as the MAC receives them
  task automatic send(input bit s, input bit e, input logic [2:0] m, input bit er);
    logic [63:0] d;
    logic [69:0] w;
    d = {$urandom, $urandom};
    w = {d, s, e, m, er};
    mac_q.push_back(w);
    avail = 1'b1;
    if (!s && !m_in) m_ferr++;
    else begin
      if (s && m_in) m_ferr++;
      exp_q.push_back(w);
      m_bytes += (e && m != 3'd0) ? longint'(m) : 8;
      if (e) begin
        m_frames++;
        if (er) m_errs++;
      end
      m_in = !e;
    end
  endtask

  task automatic frame(input int n, input logic [2:0] m, input bit er);
    for (int i = 0; i < n; i++)
      send(i == 0, i == n - 1, (i == n - 1) ? m : 3'($urandom), (i == n - 1) && er);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_frames"}, frame_cnt, lim(m_frames, 32));
    chk({tag, "_bytes"}, byte_cnt, lim(m_bytes, 32));
    chk({tag, "_errs"}, err_cnt, lim(m_errs, 32));
    chk({tag, "_ferr"}, ferr_cnt, lim(m_ferr, 32));
    chk({tag, "_sat_frames"}, s_frame_cnt, lim(m_frames, 4));
    chk({tag, "_sat_bytes"}, s_byte_cnt, lim(m_bytes, 4));
    chk({tag, "_sat_errs"}, s_err_cnt, lim(m_errs, 4));
    chk({tag, "_sat_ferr"}, s_ferr_cnt, lim(m_ferr, 4));
  endtask

  task automatic drain(input string tag, input bit rnd);
    int n;
    bit hold, nr;
    logic [69:0] held, cur;
    n = 0;
    hold = 1'b0;
    held = '0;
    while (!(mac_q.size() == 0 && !val && !out_valid) && n < 2000) begin
      cur = {out_data, out_sop, out_eop, out_mod, out_err};
      if (hold) chk({tag, "_hold"}, cur, held);
      nr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = out_valid && !nr;
      held = cur;
      out_ready = nr;
      cyc();
      n++;
    end
    out_ready = 1'b1;
    cyc();
    chk({tag, "_timeout"}, n < 2000, 1);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    while (got_q.size() != 0 && exp_q.size() != 0) chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [69:0] snap;
    int i;
    repeat (3) cyc();
    chk("rst_ren", ren, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", {out_data, out_sop, out_eop, out_mod, out_err}, 0);
    chk_cnt("rst");
    rst_n = 1'b1;
    cyc();

    frame(3, 3'd5, 1'b0);
    i = 0;
    while (!val && i < 20) begin cyc(); i++; end
    chk("lat_pre", out_valid, 0);
    cyc();
    chk("lat_valid", out_valid, 1);
    chk("lat_sop", out_sop, 1);
    drain("f3", 1'b0);
    chk("f3_frames", frame_cnt, 1);
    chk("f3_bytes", byte_cnt, 21);
    chk_cnt("f3");

    out_ready = 1'b0;
    mac_sent = 0;
    frame(10, 3'd0, 1'b0);
    repeat (5) cyc();
    snap = {out_data, out_sop, out_eop, out_mod, out_err};
    repeat (15) cyc();
    chk("bp_sent", mac_sent, 4);
    chk("bp_ren", ren, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_none_out", got_q.size(), 0);
    chk("bp_stable", {out_data, out_sop, out_eop, out_mod, out_err}, snap);
    drain("bp", 1'b0);
    chk("bp_bytes", byte_cnt, 101);
    chk_cnt("bp");

    frame(2, 3'd3, 1'b1);
    drain("er", 1'b0);
    chk("er_errs", err_cnt, 1);
    chk("er_frames", frame_cnt, 3);
    chk_cnt("er");

    send(1'b0, 1'b0, 3'd0, 1'b0);
    send(1'b1, 1'b0, 3'd0, 1'b0);
    send(1'b0, 1'b0, 3'd0, 1'b0);
    send(1'b1, 1'b0, 3'd0, 1'b0);
    send(1'b0, 1'b1, 3'd2, 1'b0);
    drain("fe", 1'b0);
    chk("fe_ferr", ferr_cnt, 2);
    chk_cnt("fe");

    for (int b = 0; b < 5; b++) begin
      for (int f = 0; f < 5; f++) begin
        if ($urandom_range(0, 5) == 0) send(1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 1'b0);
        frame(int'($urandom_range(1, 6)), 3'($urandom), 1'($urandom_range(0, 1)));
      end
      drain("rnd", 1'b1);
      chk_cnt("rnd");
    end

    out_ready = 1'b0;
    frame(4, 3'd0, 1'b0);
    i = 0;
    while (!out_valid && i < 50) begin cyc(); i++; end
    chk("pre_rst_valid", out_valid, 1);
    cyc();
    rst_n = 1'b0;
    mac_q.delete();
    avail = 1'b0;
    val = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", {out_data, out_sop, out_eop, out_mod, out_err}, 0);
    chk("mid_rst_ren", ren, 0);
    exp_q.delete();
    got_q.delete();
    m_frames = 0; m_bytes = 0; m_errs = 0; m_ferr = 0; m_in = 1'b0;
    chk_cnt("mid_rst");
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    send(1'b1, 1'b1, 3'd1, 1'b0);
    drain("post_rst", 1'b0);
    chk("post_rst_frames", frame_cnt, 1);
    chk("post_rst_bytes", byte_cnt, 1);
    chk("post_rst_ferr", ferr_cnt, 0);
    chk_cnt("post_rst");

    for (int f = 0; f < 20; f++) send(1'b1, 1'b1, 3'($urandom), 1'b0);
    drain("sat", 1'b1);
    chk("sat_frames4", s_frame_cnt, 15);
    chk("sat_frames32", frame_cnt, 21);
    chk_cnt("sat");

    send(1'b1, 1'b1, 3'd3, 1'b0);
    i = 0;
    while (!(val && eop) && i < 50) begin cyc(); i++; end
    chk("clr_seen_eop", val && eop, 1);
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    m_frames = 0; m_bytes = 0; m_errs = 0; m_ferr = 0;
    chk("clr_frames4", s_frame_cnt, 0);
    chk("clr_frames32", frame_cnt, 0);
    drain("clr", 1'b0);
    chk_cnt("clr");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
